mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction-fetch port
// and a data port. Data normally wins, but a fetch that has waited through
// STARVE_LIMIT consecutive data grants is served next. Reads return with a
// fixed one-cycle latency to whichever port owned the read.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req_i,
  input  logic [31:0]           i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [31:0]           i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [31:0]           d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  owner_t        owner, owner_next;
  logic [CW-1:0] streak_cnt, streak_next;
  logic [31:0]   i_hold, d_hold;
  logic          fetch_gnt, data_gnt, starved;

  // Only the low word-index bits address the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr_i[31:ADDR_WIDTH], d_addr_i[31:ADDR_WIDTH]};

  assign starved = (streak_cnt == CW'(STARVE_LIMIT));

  // Grant selection, streak tracking and read-ownership for next cycle.
  // Grants are forced off while reset is asserted so every output is 0.
  always_comb begin
    fetch_gnt   = 1'b0;
    data_gnt    = 1'b0;
    streak_next = streak_cnt;
    owner_next  = OWN_NONE;
    if (reset_n) begin
      if (i_req_i && (!d_req_i || starved)) begin
        fetch_gnt = 1'b1;
      end else if (d_req_i) begin
        data_gnt = 1'b1;
      end
    end
    if (!i_req_i || fetch_gnt) begin
      streak_next = '0;
    end else if (data_gnt && !starved) begin
      streak_next = streak_cnt + 1'b1;
    end
    if (fetch_gnt) begin
      owner_next = OWN_FETCH;
    end else if (data_gnt && !d_we_i) begin
      owner_next = OWN_DATA;
    end
  end

  // State register: response owner and starvation streak.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= OWN_NONE;
      streak_cnt <= '0;
    end else begin
      owner      <= owner_next;
      streak_cnt <= streak_next;
    end
  end

  // Per-port holding registers keep the last returned read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (owner == OWN_FETCH) i_hold <= mem_rdata_i;
      if (owner == OWN_DATA)  d_hold <= mem_rdata_i;
    end
  end

  assign i_gnt_o     = fetch_gnt;
  assign d_gnt_o     = data_gnt;
  assign mem_en_o    = fetch_gnt | data_gnt;
  assign mem_we_o    = data_gnt & d_we_i;
  assign mem_addr_o  = fetch_gnt ? i_addr_i[ADDR_WIDTH-1:0] :
                       data_gnt  ? d_addr_i[ADDR_WIDTH-1:0] : '0;
  assign mem_wdata_o = reset_n ? d_wdata_i : '0;

  assign i_rvalid_o  = (owner == OWN_FETCH);
  assign d_rvalid_o  = (owner == OWN_DATA);
  assign i_rdata_o   = i_rvalid_o ? mem_rdata_i : i_hold;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : d_hold;

endmodule
